reaction_round_ctrl: RTL and testbench
======================================

# reaction_round_ctrl

Parametrised game controller for the reaction-timer board: runs one reaction round per start press (random wait, LED on, BCD reaction count), tracks the best score across rounds, and drives packed BCD digits to the seven-segment decoders. It sits between the debounced buttons and LFSR delay source upstream and the per-digit `SevenSegment` decoders downstream. It replaces the fixed four-digit, single-round top-level control with a generalised digit count, tick rate and minimum delay, plus false-start detection and round statistics.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits in the reaction count (1..8).
- `DELAY_W`, 12: width of the random delay input.
- `TICK_DIV`, 50000: clk cycles per count tick (1 ms at 50 MHz); ≥2.
- `MIN_DELAY`, 500: ticks added to the random value before the LED lights.

Ports:
- `clk` in 1: system clock; only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_btn` in 1: single-cycle pulse, debounced upstream; starts a round.
- `react_btn` in 1: single-cycle pulse; player reaction.
- `show_best` in 1: level; selects best score for display when not mid-round.
- `rand_delay` in DELAY_W: free-running LFSR value, sampled on start.
- `led` out 1: reaction stimulus LED.
- `digits` out 4*DIGITS: packed BCD, digit 0 in [3:0] (least significant).
- `state` out 3: current FSM state encoding.
- `false_start` out 1: high while in FALSE.
- `new_best` out 1: one-cycle pulse when the best score is updated.
- `rounds` out 8: completed valid rounds, saturates at 255.

## Operation
- States: IDLE=0, WAIT=1, RUN=2, DONE=3, FALSE=4.
- IDLE/DONE/FALSE + `start_btn` → WAIT. On entry: load wait counter with `rand_delay + MIN_DELAY` (DELAY_W+1 bits, no overflow), clear BCD count, restart the tick prescaler.
- WAIT: decrement on each tick; at 0 → RUN, `led`=1, BCD count cleared, prescaler restarted.
- WAIT + `react_btn` → FALSE (false-start detection); `start_btn` in WAIT/RUN is ignored.
- RUN: BCD count +1 per tick, decimal carry per digit. `react_btn` → DONE, count frozen. If the count reaches all 9s, it saturates and the FSM goes to DONE with `led`=0; this is a timeout and does not count as a valid round.
- DONE (valid react): `rounds`+1; if count < best, best ← count and `new_best` is pulsed in the same cycle as the DONE entry.
- The best register resets to all 9s. Comparison is a BCD magnitude compare, most significant digit first.
- `digits`:
  - IDLE, and DONE/FALSE with `show_best`=1: best.
  - WAIT: all zeros.
  - RUN/DONE: live or frozen count.
  - FALSE with `show_best`=0: every nibble 4'hE (error glyph).
- `led` is 1 only in RUN.

## Timing
- Reset values: state=IDLE, `led`=0, `digits`=all 4'h9 (best), `false_start`=0, `new_best`=0, `rounds`=0, prescaler=0.
- Outputs are registered. `led` rises on the clk edge where WAIT exits.
- A tick occurs every TICK_DIV cycles. The first tick after entering WAIT or RUN is exactly TICK_DIV cycles after entry.
- A `react_btn` in RUN on the same cycle as a tick freezes the pre-increment count.
- A `react_btn` on the same cycle as the WAIT→RUN transition counts as a false start.
- Asserting `rst_n` mid-round returns to IDLE immediately and clears best and `rounds`.

## Configuration
- `FALSE_START_EN` defined: behaviour as above.
- `FALSE_START_EN` undefined: `react_btn` in WAIT is ignored, FALSE is unreachable, and `false_start` is tied to 0.

## Test plan
Common parameters: DIGITS=3, TICK_DIV=4, MIN_DELAY=2.
- Reset then idle: `digits`=12'h999, `led`=0, `rounds`=0, `state`=0.
- `rand_delay`=3, start pulse: `led` rises 20 cycles after the start-pulse edge. React 30 cycles after `led` rises → `digits`=12'h007, `new_best` pulses, `rounds`=1.
- Second round with reaction count 12'h010 → best stays 12'h007, no `new_best` pulse. With `show_best`=1, `digits`=12'h007.
- React during WAIT with the macro defined → state=4, `digits`=12'hEEE, `led` stays 0, `rounds` unchanged. Without the macro: round completes normally.
- No react for 4000+ cycles → count saturates at 12'h999, DONE, `rounds` unchanged.
- `rst_n` low during RUN → next cycle state=0, `led`=0, best=12'h999.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round controller: random wait, LED stimulus, BCD reaction count, best score, display mux.
// All outputs registered (one edge after the decision); pulse inputs, no backpressure. Define FALSE_START_EN for early-press detection.
module reaction_round_ctrl #(
   parameter int DIGITS    = 4,
   parameter int DELAY_W   = 12,
   parameter int TICK_DIV  = 50000,
   parameter int MIN_DELAY = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_btn,
   input  logic                  react_btn,
   input  logic                  show_best,
   input  logic [DELAY_W-1:0]    rand_delay,
   output logic                  led,
   output logic [4*DIGITS-1:0]   digits,
   output logic [2:0]            state,
   output logic                  false_start,
   output logic                  new_best,
   output logic [7:0]            rounds
);

   localparam int CNT_W  = 4 * DIGITS;
   localparam int WAIT_W = DELAY_W + 1;
   localparam int PRE_W  = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
   localparam logic [CNT_W-1:0]  ALL_ERR   = {DIGITS{4'hE}};
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [WAIT_W-1:0] MIN_W     = WAIT_W'(MIN_DELAY);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_FALSE = 3'd4
   } state_t;

   state_t             state_q, state_nxt;
   logic [PRE_W-1:0]   presc_q;
   logic [WAIT_W-1:0]  wait_q, wait_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
   logic [CNT_W-1:0]   best_q, best_nxt;
   logic [7:0]         rounds_q, rounds_nxt;
   logic               tick, enter_wait, enter_run;
   logic               cnt_full, react_ok, early_react, better;
   logic               led_nxt, nb_nxt;
   logic [CNT_W-1:0]   digits_nxt;

   function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Magnitude compare from the most significant digit down.
   function automatic logic bcd_lt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic decided;
      logic lt;
      decided = 1'b0;
      lt      = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
            decided = 1'b1;
            lt      = (a[4*i +: 4] < b[4*i +: 4]);
         end
      end
      return lt;
   endfunction

   assign tick     = (presc_q == PRE_LAST);
   assign cnt_inc  = bcd_inc(cnt_q);
   assign cnt_full = (cnt_inc == ALL_NINES);
   assign react_ok = (state_q == S_RUN) && react_btn;
   assign better   = bcd_lt(cnt_q, best_q);

`ifdef FALSE_START_EN
   assign early_react = react_btn;
`else
   assign early_react = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // An early press wins over the tick that would have lit the LED.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_FALSE: begin
            if (start_btn) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (early_react) begin
               state_nxt = S_FALSE;
            end else if (tick && (wait_q <= WAIT_W'(1))) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (react_btn || (tick && cnt_full)) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign enter_wait = (state_nxt == S_WAIT) && (state_q != S_WAIT);
   assign enter_run  = (state_nxt == S_RUN)  && (state_q != S_RUN);

   always_comb begin
      wait_nxt   = wait_q;
      cnt_nxt    = cnt_q;
      best_nxt   = best_q;
      rounds_nxt = rounds_q;
      nb_nxt     = 1'b0;
      if (enter_wait) begin
         wait_nxt = {1'b0, rand_delay} + MIN_W;
         cnt_nxt  = '0;
      end else if ((state_q == S_WAIT) && tick && (wait_q != '0)) begin
         wait_nxt = wait_q - 1'b1;
      end
      if (enter_run) begin
         cnt_nxt = '0;
      end else if ((state_q == S_RUN) && tick && !react_btn) begin
         cnt_nxt = cnt_inc;
      end
      if (react_ok) begin
         rounds_nxt = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
         if (better) begin
            best_nxt = cnt_q;
            nb_nxt   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         wait_q   <= '0;
         cnt_q    <= '0;
         best_q   <= ALL_NINES;
         rounds_q <= '0;
      end else begin
         presc_q  <= (enter_wait || enter_run || tick) ? '0 : presc_q + 1'b1;
         wait_q   <= wait_nxt;
         cnt_q    <= cnt_nxt;
         best_q   <= best_nxt;
         rounds_q <= rounds_nxt;
      end
   end

   always_comb begin
      led_nxt    = (state_nxt == S_RUN);
      digits_nxt = best_nxt;
      unique case (state_nxt)
         S_WAIT:  digits_nxt = '0;
         S_RUN:   digits_nxt = cnt_nxt;
         S_DONE:  digits_nxt = show_best ? best_nxt : cnt_nxt;
         S_FALSE: digits_nxt = show_best ? best_nxt : ALL_ERR;
         default: digits_nxt = best_nxt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led      <= 1'b0;
         digits   <= ALL_NINES;
         new_best <= 1'b0;
      end else begin
         led      <= led_nxt;
         digits   <= digits_nxt;
         new_best <= nb_nxt;
      end
   end

`ifdef FALSE_START_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         false_start <= 1'b0;
      end else begin
         false_start <= (state_nxt == S_FALSE);
      end
   end
`else
   assign false_start = 1'b0;
`endif

   assign state  = state_q;
   assign rounds = rounds_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl (DIGITS=3, TICK_DIV=4, MIN_DELAY=2); round outcomes predicted from
// cycle arithmetic and an integer best/rounds model. Honours FALSE_START_EN when defined.
module tb_reaction_round_ctrl;
   localparam int DIGITS    = 3;
   localparam int DELAY_W   = 12;
   localparam int TICK_DIV  = 4;
   localparam int MIN_DELAY = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start_btn;
   logic                react_btn;
   logic                show_best;
   logic [DELAY_W-1:0]  rand_delay;
   logic                led;
   logic [4*DIGITS-1:0] digits;
   logic [2:0]          state;
   logic                false_start;
   logic                new_best;
   logic [7:0]          rounds;

   int vectors     = 0;
   int miscompares = 0;
   int m_best;
   int m_rounds;

   reaction_round_ctrl #(
      .DIGITS(DIGITS), .DELAY_W(DELAY_W), .TICK_DIV(TICK_DIV), .MIN_DELAY(MIN_DELAY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .react_btn(react_btn),
      .show_best(show_best), .rand_delay(rand_delay), .led(led), .digits(digits),
      .state(state), .false_start(false_start), .new_best(new_best), .rounds(rounds)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r       = '0;
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick1();
      @(posedge clk);
      #1;
      rand_delay = DELAY_W'($urandom);
   endtask

   // k>0: react k edges after the LED rises; k==0: never react (timeout).
   // fs_at>0: press react at that edge index inside WAIT.
   task automatic run_round(input int d, input int k, input int fs_at);
      int w;
      int n;
      int exp_cnt;
      bit exp_nb;
      w = d + MIN_DELAY;
      if (w < 1) w = 1;
      rand_delay = DELAY_W'(d);
      start_btn  = 1'b1;
      tick1();
      start_btn  = 1'b0;
      check("wait_state", 32'(state), 1);
      check("wait_digits", 32'(digits), 0);
      n = 0;
      while (!led && n < 4*w + 8) begin
         start_btn = (n == 1);
         react_btn = (fs_at != 0) && (n + 1 == fs_at);
         tick1();
         n++;
         start_btn = 1'b0;
         react_btn = 1'b0;
`ifdef FALSE_START_EN
         if (fs_at != 0 && n == fs_at) break;
`endif
      end
`ifdef FALSE_START_EN
      if (fs_at != 0) begin
         check("fs_state", 32'(state), 4);
         check("fs_digits", 32'(digits), 32'h0000_0EEE);
         check("fs_led", 32'(led), 0);
         check("fs_flag", 32'(false_start), 1);
         check("fs_rounds", 32'(rounds), m_rounds);
         check("fs_new_best", 32'(new_best), 0);
         show_best = 1'b1;
         tick1();
         check("fs_show_best", 32'(digits), to_bcd(m_best));
         show_best = 1'b0;
         tick1();
         check("fs_digits_back", 32'(digits), 32'h0000_0EEE);
         return;
      end
`endif
      check("led_rise_cycles", n, 4*w);
      check("run_state", 32'(state), 2);
      check("run_digits", 32'(digits), 0);
      check("false_start_low", 32'(false_start), 0);
      n = 0;
      if (k > 0) begin
         while (n < k) begin
            react_btn = (n + 1 == k);
            start_btn = (n == 1) && (k > 3);
            tick1();
            n++;
            react_btn = 1'b0;
            start_btn = 1'b0;
         end
         exp_cnt  = (k - 1) / TICK_DIV;
         m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
         exp_nb   = (exp_cnt < m_best);
         if (exp_nb) m_best = exp_cnt;
         check("done_state", 32'(state), 3);
         check("done_digits", 32'(digits), to_bcd(exp_cnt));
         check("done_led", 32'(led), 0);
         check("done_new_best", 32'(new_best), 32'(exp_nb));
         check("done_rounds", 32'(rounds), m_rounds);
         tick1();
         check("new_best_clear", 32'(new_best), 0);
      end else begin
         while (state != 3'd3 && n < 4100) begin
            tick1();
            n++;
         end
         check("timeout_cycles", n, 999 * TICK_DIV);
         check("timeout_digits", 32'(digits), 32'h0000_0999);
         check("timeout_led", 32'(led), 0);
         check("timeout_new_best", 32'(new_best), 0);
         check("timeout_rounds", 32'(rounds), m_rounds);
      end
   endtask

   initial begin
      int n;
      rst_n      = 1'b1;
      start_btn  = 1'b0;
      react_btn  = 1'b0;
      show_best  = 1'b0;
      rand_delay = '0;
      m_best     = 999;
      m_rounds   = 0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_state", 32'(state), 0);
      check("reset_led", 32'(led), 0);
      check("reset_digits", 32'(digits), 32'h0000_0999);
      check("reset_rounds", 32'(rounds), 0);
      check("reset_false_start", 32'(false_start), 0);
      check("reset_new_best", 32'(new_best), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick1();
      tick1();
      check("idle_state", 32'(state), 0);
      check("idle_digits", 32'(digits), 32'h0000_0999);

      run_round(3, 30, 0);
      run_round(5, 42, 0);
      react_btn = 1'b1;
      tick1();
      react_btn = 1'b0;
      check("react_in_done_state", 32'(state), 3);
      check("react_in_done_rounds", 32'(rounds), m_rounds);
      show_best = 1'b1;
      tick1();
      check("show_best_done", 32'(digits), to_bcd(m_best));
      show_best = 1'b0;
      tick1();
      check("count_done", 32'(digits), 32'h0000_0010);

      run_round(2, 25, 3);
      run_round(0, 60, 8);
      repeat (6) run_round(int'($urandom_range(0, 12)), int'($urandom_range(12, 160)), 0);
      run_round(int'($urandom_range(0, 5)), 0, 0);
      show_best = 1'b1;
      tick1();
      check("show_best_after_timeout", 32'(digits), to_bcd(m_best));
      show_best = 1'b0;
      tick1();

      rand_delay = DELAY_W'(1);
      start_btn  = 1'b1;
      tick1();
      start_btn  = 1'b0;
      n = 0;
      while (!led && n < 100) begin
         tick1();
         n++;
      end
      repeat (10) tick1();
      check("pre_reset_state", 32'(state), 2);
      rst_n = 1'b0;
      #1;
      m_best   = 999;
      m_rounds = 0;
      check("midrun_reset_state", 32'(state), 0);
      check("midrun_reset_led", 32'(led), 0);
      check("midrun_reset_digits", 32'(digits), to_bcd(m_best));
      check("midrun_reset_rounds", 32'(rounds), m_rounds);
      tick1();
      rst_n = 1'b1;
      tick1();
      check("post_reset_state", 32'(state), 0);
      check("post_reset_digits", 32'(digits), 32'h0000_0999);
      run_round(0, 50, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
